// File: rtl/adder_pipe_wrapper.sv
// Pipelined add/sub, carry chain cut into SEGS segments (one per stage); latency SEGS cycles.
// Bubble-collapsing valid/ready: a stage loads when empty or when its contents move on.
module adder_pipe_wrapper #(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SW = WIDTH / SEGS;

  if (WIDTH < 2 || SEGS < 1 || (WIDTH % SEGS) != 0) begin : g_bad_params
    $error("adder_pipe_wrapper: WIDTH must be >= 2 and a multiple of SEGS >= 1");
  end

  logic [SEGS:0]    vld;
  logic [SEGS:0]    load;
  logic [WIDTH-1:0] op_a [SEGS];
  logic [WIDTH-1:0] op_b [SEGS];
  logic [WIDTH-1:0] part [SEGS];
  logic             cy   [SEGS];
  logic [WIDTH-1:0] nxt  [SEGS];
  logic             nco  [SEGS];

  always_comb begin
    load[SEGS] = !vld[SEGS] || out_ready;
    for (int k = SEGS - 1; k >= 0; k--) begin
      load[k] = !vld[k] || load[k+1];
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld[SEGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      if (load[0]) vld[0] <= in_valid;
      for (int k = 1; k <= SEGS; k++) begin
        if (load[k]) vld[k] <= vld[k-1];
      end
    end
  end

  // Segment k is resolved from the registers of stage k into stage k+1.
  always_comb begin
    for (int k = 0; k < SEGS; k++) begin
      logic [SW:0] seg;
      seg = {1'b0, op_a[k][k*SW +: SW]} + {1'b0, op_b[k][k*SW +: SW]} + {{SW{1'b0}}, cy[k]};
      nxt[k] = part[k];
      nxt[k][k*SW +: SW] = seg[SW-1:0];
      nco[k] = seg[SW];
    end
  end

  // Subtract is folded into the input register: b inverted, carry-in forced to 1.
  always_ff @(posedge clk) begin
    if (load[0] && in_valid) begin
      op_a[0] <= a;
      op_b[0] <= sub ? ~b : b;
      cy[0]   <= sub | cin;
      part[0] <= '0;
    end
    for (int k = 1; k < SEGS; k++) begin
      if (load[k] && vld[k-1]) begin
        op_a[k] <= op_a[k-1];
        op_b[k] <= op_b[k-1];
        part[k] <= nxt[k-1];
        cy[k]   <= nco[k-1];
      end
    end
  end

  // Carry into the MSB is recovered as a^b^sum at that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (load[SEGS] && vld[SEGS-1]) begin
      sum  <= nxt[SEGS-1];
      cout <= nco[SEGS-1];
      ovf  <= op_a[SEGS-1][WIDTH-1] ^ op_b[SEGS-1][WIDTH-1] ^ nxt[SEGS-1][WIDTH-1] ^ nco[SEGS-1];
    end
  end

endmodule

// File: tb/tb_adder_pipe_wrapper.sv
// Scoreboard bench for adder_pipe_wrapper: 32/4 main instance plus 8/1 and 8/8 corner instances.
module tb_adder_pipe_wrapper;
  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  logic         c1_in_valid, c1_in_ready, c1_out_valid, c1_cout, c1_ovf;
  logic [7:0]   c1_sum;
  logic         c8_in_valid, c8_in_ready, c8_out_valid, c8_cout, c8_ovf;
  logic [7:0]   c8_sum;
  logic [7:0]   c_a, c_b;
  logic         c_cin, c_sub;
  logic         c_ordy = 1'b1;

  adder_pipe_wrapper #(.WIDTH(W), .SEGS(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  adder_pipe_wrapper #(.WIDTH(8), .SEGS(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
    .a(c_a), .b(c_b), .cin(c_cin), .sub(c_sub), .out_valid(c1_out_valid), .out_ready(c_ordy),
    .sum(c1_sum), .cout(c1_cout), .ovf(c1_ovf));

  adder_pipe_wrapper #(.WIDTH(8), .SEGS(8)) dut_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(c8_in_valid), .in_ready(c8_in_ready),
    .a(c_a), .b(c_b), .cin(c_cin), .sub(c_sub), .out_valid(c8_out_valid), .out_ready(c_ordy),
    .sum(c8_sum), .cout(c8_cout), .ovf(c8_ovf));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        s;
    logic [31:0] es;
    logic        eco;
    logic        eov;
  } vec_t;

  exp_t exp_q[$];
  int   pop_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: full-width add, overflow from operand/result signs.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic s);
    logic [31:0] yy;
    logic        cc;
    logic [32:0] r;
    logic        v;
    yy = s ? ~y : y;
    cc = s ? 1'b1 : c;
    r  = {1'b0, x} + {1'b0, yy} + {32'd0, cc};
    v  = (x[31] == yy[31]) && (r[31] != x[31]);
    return {v, r};
  endfunction

  // Monitor: pops on every output transfer and checks hold behaviour while stalled.
  logic [31:0] h_sum;
  logic        h_cout, h_ovf;
  bit          stall_prev = 0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold out_valid", out_valid, 1);
        chk("hold sum", sum, h_sum);
        chk("hold cout/ovf", {cout, ovf}, {h_cout, h_ovf});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected result: got sum %0h with empty scoreboard, expected none", sum);
        end else begin
          e = exp_q.pop_front();
          chk("result sum", sum, e.s);
          chk("result cout", cout, e.co);
          chk("result ovf", ovf, e.ov);
          if (e.lat) chk("latency", cyc - e.acc, S);
          pop_cyc.push_back(cyc);
        end
      end
      stall_prev = out_valid && !out_ready;
      h_sum  = sum;
      h_cout = cout;
      h_ovf  = ovf;
    end
  end

  task automatic offer(input logic [31:0] ta, input logic [31:0] tb2, input logic tc,
                       input logic ts, input logic [31:0] es, input logic eco, input logic eov,
                       input logic orr, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1; out_ready = orr;
    #1;
    acc = in_ready;
    if (acc) begin
      e.s = es; e.co = eco; e.ov = eov; e.acc = cyc + 1; e.lat = lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic offer_rand(input logic orr, input bit lat, output bit acc);
    logic [31:0] ta, tb2;
    logic        tc, ts;
    logic [33:0] m;
    ta = $urandom; tb2 = $urandom; tc = 1'($urandom_range(0, 1)); ts = 1'($urandom_range(0, 1));
    m = model(ta, tb2, tc, ts);
    offer(ta, tb2, tc, ts, m[31:0], m[32], m[33], orr, lat, acc);
  endtask

  task automatic send(input vec_t v);
    bit acc = 0;
    int w = 0;
    while (!acc && w < 50) begin
      offer(v.a, v.b, v.c, v.s, v.es, v.eco, v.eov, 1'b1, 1'b1, acc);
      w++;
    end
    if (!acc) begin
      n_chk++;
      n_err++;
      $display("FAIL send timeout: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic drain(input string nm);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " drain outstanding"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  vec_t dir[10];

  initial begin
    bit acc;
    int w, cnt;
    dir = '{
      '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
      '{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1},
      '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0},
      '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1},
      '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0},
      '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0},
      '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1},
      '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0},
      '{32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0, 32'h0001FFFF, 1'b0, 1'b0}
    };
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    c1_in_valid = 1'b0; c8_in_valid = 1'b0; c_a = '0; c_b = '0; c_cin = 1'b0; c_sub = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset sum", sum, 0);
    chk("reset cout/ovf", {cout, ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", in_ready, 1);

    // Directed vectors, one at a time through an empty pipe.
    foreach (dir[i]) begin
      send(dir[i]);
      drain("directed");
    end

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) offer_rand(1'b1, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset in_ready after release", in_ready, 1);
    repeat (10) @(negedge clk);

    // Corner configurations.
    @(negedge clk);
    c_a = 8'h7F; c_b = 8'h01; c_cin = 1'b0; c_sub = 1'b0; c1_in_valid = 1'b1;
    #1 chk("c1 in_ready", c1_in_ready, 1);
    @(negedge clk);
    c1_in_valid = 1'b0;
    w = 0;
    while (!c1_out_valid && w < 20) begin @(negedge clk); w++; end
    chk("c1 latency", w, 1);
    chk("c1 sum", c1_sum, 8'h80);
    chk("c1 cout/ovf", {c1_cout, c1_ovf}, 2'b01);

    @(negedge clk);
    c_a = 8'hFF; c_b = 8'h00; c_cin = 1'b1; c_sub = 1'b0; c8_in_valid = 1'b1;
    #1 chk("c8 in_ready", c8_in_ready, 1);
    @(negedge clk);
    c8_in_valid = 1'b0;
    w = 0;
    while (!c8_out_valid && w < 30) begin @(negedge clk); w++; end
    chk("c8 latency", w, 8);
    chk("c8 sum", c8_sum, 8'h00);
    chk("c8 cout/ovf", {c8_cout, c8_ovf}, 2'b10);

    // Streaming at full rate.
    pop_cyc.delete();
    for (int i = 0; i < 1000; i++) begin
      offer_rand(1'b1, 1'b1, acc);
      if (!acc) begin
        n_chk++;
        n_err++;
        $display("FAIL stream in_ready: got 0 at item %0d, expected 1", i);
      end else begin
        n_chk++;
      end
    end
    drain("stream");
    chk("stream result count", pop_cyc.size(), 1000);
    if (pop_cyc.size() == 1000) chk("stream span cycles", pop_cyc[999] - pop_cyc[0], 999);

    // Backpressure: fill with out_ready low, then release randomly.
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      offer_rand(1'b0, 1'b0, acc);
      if (acc) cnt++;
    end
    chk("bp accepted before stall", cnt, 5);
    chk("bp in_ready when full", acc, 0);
    chk("bp out_valid when full", out_valid, 1);
    for (int i = 0; i < 60; i++) offer_rand(1'($urandom_range(0, 1)), 1'b0, acc);
    drain("backpressure");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
